// File: rtl/dffram_wb_port.sv
// dffram_wb_port: Wishbone-classic responder driving one DFFRAM macro port.
// Each bus access is turned into a single-cycle RAM strobe. A registered
// acknowledge follows one cycle later, with read data taken from ram_do.
// Optional feature: define DFFRAM_WB_ZEROIZE_EN to zero-fill the whole array
// after reset. busy_o stays high until the fill completes.
module dffram_wb_port #(
  parameter int AW = 8
) (
  input  logic          CLK,
  input  logic          RST,
  input  logic          wb_cyc_i,
  input  logic          wb_stb_i,
  input  logic          wb_we_i,
  input  logic [3:0]    wb_sel_i,
  input  logic [AW+1:0] wb_adr_i,
  input  logic [31:0]   wb_dat_i,
  output logic [31:0]   wb_dat_o,
  output logic          wb_ack_o,
  output logic          busy_o,
  output logic          ram_en,
  output logic [3:0]    ram_we,
  output logic [AW-1:0] ram_a,
  output logic [31:0]   ram_di,
  input  logic [31:0]   ram_do
);

`ifdef DFFRAM_WB_ZEROIZE_EN
  typedef enum logic [1:0] {
    ST_INIT = 2'd0,
    ST_ZERO = 2'd1,
    ST_IDLE = 2'd2,
    ST_ACK  = 2'd3
  } state_t;
`else
  typedef enum logic [1:0] {
    ST_INIT = 2'd0,
    ST_IDLE = 2'd2,
    ST_ACK  = 2'd3
  } state_t;
`endif

  state_t state_r;
  state_t next_state_s;
  logic   we_r;
  logic   req_s;
  logic   unused_adr_s;

  // The byte offset within a word is not used by a word-wide RAM port.
  assign unused_adr_s = ^wb_adr_i[1:0];
  assign req_s        = wb_cyc_i & wb_stb_i;

  // State register; reset parks the FSM in INIT.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state_r <= ST_INIT;
    end else begin
      state_r <= next_state_s;
    end
  end

  // Remember the direction of the accepted access for the ACK cycle.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      we_r <= 1'b0;
    end else if ((state_r == ST_IDLE) && req_s) begin
      we_r <= wb_we_i;
    end else begin
      we_r <= we_r;
    end
  end

`ifdef DFFRAM_WB_ZEROIZE_EN
  logic [AW-1:0] cnt_r;
  logic          last_s;

  assign last_s = (cnt_r == {AW{1'b1}});

  // Fill word counter; it advances only while zero-filling and restarts on reset.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      cnt_r <= {AW{1'b0}};
    end else if (state_r == ST_ZERO) begin
      cnt_r <= cnt_r + {{(AW-1){1'b0}}, 1'b1};
    end else begin
      cnt_r <= {AW{1'b0}};
    end
  end
`endif

  // Next-state decode and all port outputs; the RAM port idles at zero.
  always_comb begin
    next_state_s = state_r;
    ram_en       = 1'b0;
    ram_we       = 4'h0;
    ram_a        = {AW{1'b0}};
    ram_di       = 32'h0000_0000;
    wb_ack_o     = 1'b0;
    wb_dat_o     = 32'h0000_0000;
    busy_o       = 1'b0;
    case (state_r)
      ST_INIT: begin
`ifdef DFFRAM_WB_ZEROIZE_EN
        busy_o       = 1'b1;
        next_state_s = ST_ZERO;
`else
        next_state_s = ST_IDLE;
`endif
      end
`ifdef DFFRAM_WB_ZEROIZE_EN
      ST_ZERO: begin
        busy_o = 1'b1;
        ram_en = 1'b1;
        ram_we = 4'hF;
        ram_a  = cnt_r;
        ram_di = 32'h0000_0000;
        if (last_s) begin
          next_state_s = ST_IDLE;
        end else begin
          next_state_s = ST_ZERO;
        end
      end
`endif
      ST_IDLE: begin
        if (req_s) begin
          ram_en       = 1'b1;
          ram_we       = wb_we_i ? wb_sel_i : 4'h0;
          ram_a        = wb_adr_i[AW+1:2];
          ram_di       = wb_dat_i;
          next_state_s = ST_ACK;
        end else begin
          next_state_s = ST_IDLE;
        end
      end
      ST_ACK: begin
        wb_ack_o = 1'b1;
        if (!we_r) begin
          wb_dat_o = ram_do;
        end else begin
          wb_dat_o = 32'h0000_0000;
        end
        next_state_s = ST_IDLE;
      end
      default: begin
        next_state_s = ST_INIT;
      end
    endcase
  end

endmodule

// File: tb/tb_dffram_wb_port.sv
// Directed bench for dffram_wb_port with a behavioural 256x32 DFFRAM model.
// Define DFFRAM_WB_ZEROIZE_EN for both files to also exercise the zero fill.
module tb_dffram_wb_port;
  localparam int AW = 8;

  logic          clk = 1'b0;
  logic          rst;
  logic          cyc, stb, we;
  logic [3:0]    sel;
  logic [AW+1:0] adr;
  logic [31:0]   dat_i;
  logic [31:0]   dat_o;
  logic          ack, busy;
  logic          ram_en;
  logic [3:0]    ram_we;
  logic [AW-1:0] ram_a;
  logic [31:0]   ram_di;
  logic [31:0]   ram_do;

  logic [31:0]   mem [0:255];
  int            errors = 0;
  int            checks = 0;
  logic [7:0]    pat;
  int            k;
  int            n;
  int            early;

  always #5 clk = ~clk;

  dffram_wb_port #(.AW(AW)) dut (
    .CLK(clk), .RST(rst),
    .wb_cyc_i(cyc), .wb_stb_i(stb), .wb_we_i(we), .wb_sel_i(sel),
    .wb_adr_i(adr), .wb_dat_i(dat_i), .wb_dat_o(dat_o), .wb_ack_o(ack),
    .busy_o(busy), .ram_en(ram_en), .ram_we(ram_we), .ram_a(ram_a),
    .ram_di(ram_di), .ram_do(ram_do)
  );

  // DFFRAM model: byte-lane writes, read word registered on every enabled edge.
  always @(posedge clk) begin
    if (ram_en) begin
      for (int b = 0; b < 4; b++) begin
        if (ram_we[b]) mem[ram_a][8*b +: 8] <= ram_di[8*b +: 8];
      end
      ram_do <= mem[ram_a];
    end
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%08h expected=%08h", tag, obs, exp);
    end
  endtask

  // One complete bus access: strobe cycle, ack cycle, then a quiet cycle.
  task automatic access(input logic w, input logic [3:0] s, input logic [AW+1:0] a,
                        input logic [31:0] d, input logic [31:0] exp_rd, input string tag);
    logic [31:0] exp_a;
    exp_a = {24'h0, a[AW+1:2]};
    @(negedge clk);
    cyc = 1'b1; stb = 1'b1; we = w; sel = s; adr = a; dat_i = d;
    #1;
    check({tag, "_en"}, {31'h0, ram_en}, 32'h1);
    check({tag, "_we"}, {28'h0, ram_we}, w ? {28'h0, s} : 32'h0);
    check({tag, "_a"}, {24'h0, ram_a}, exp_a);
    check({tag, "_di"}, ram_di, d);
    check({tag, "_noack"}, {31'h0, ack}, 32'h0);
    @(posedge clk); #1;
    check({tag, "_ack"}, {31'h0, ack}, 32'h1);
    check({tag, "_en_in_ack"}, {31'h0, ram_en}, 32'h0);
    check({tag, "_dat"}, dat_o, w ? 32'h0 : exp_rd);
    @(negedge clk);
    cyc = 1'b0; stb = 1'b0; we = 1'b0; sel = 4'h0; adr = '0; dat_i = 32'h0;
    @(posedge clk); #1;
    check({tag, "_ack_drop"}, {31'h0, ack}, 32'h0);
    check({tag, "_idle_a"}, {24'h0, ram_a}, 32'h0);
  endtask

  task automatic wait_ready();
    int m;
    m = 0;
    while (busy && m < 2000) begin
      @(posedge clk); #1;
      m++;
    end
    check("ready", {31'h0, busy}, 32'h0);
  endtask

  initial begin
    for (int i = 0; i < 256; i++) mem[i] = 32'hA5A5_A5A5;
    ram_do = 32'hA5A5_A5A5;
    rst = 1'b1; cyc = 1'b0; stb = 1'b0; we = 1'b0; sel = 4'h0; adr = '0; dat_i = 32'h0;
    repeat (3) @(posedge clk);
    #1;
    check("rst_ack", {31'h0, ack}, 32'h0);
    check("rst_dat", dat_o, 32'h0);
    check("rst_en", {31'h0, ram_en}, 32'h0);
    check("rst_we", {28'h0, ram_we}, 32'h0);
    check("rst_a", {24'h0, ram_a}, 32'h0);
    check("rst_di", ram_di, 32'h0);
`ifdef DFFRAM_WB_ZEROIZE_EN
    check("rst_busy", {31'h0, busy}, 32'h1);
    // Release reset with a read of the top word already pending.
    @(negedge clk);
    rst = 1'b0; cyc = 1'b1; stb = 1'b1; we = 1'b0; sel = 4'hF; adr = 10'h3FC;
    n = 0; early = 0;
    while (busy && n < 1000) begin
      if (ack) early++;
      @(posedge clk); #1;
      n++;
    end
    check("zero_busy_cycles", n, 32'd257);
    check("zero_early_ack", early, 32'd0);
    check("zero_req_en", {31'h0, ram_en}, 32'h1);
    check("zero_req_a", {24'h0, ram_a}, 32'h0000_00FF);
    @(posedge clk); #1;
    check("zero_ack", {31'h0, ack}, 32'h1);
    check("zero_dat", dat_o, 32'h0);
    @(negedge clk);
    cyc = 1'b0; stb = 1'b0; adr = '0;
`else
    check("rst_busy", {31'h0, busy}, 32'h0);
    @(negedge clk);
    rst = 1'b0;
    @(posedge clk); #1;
    check("init_busy", {31'h0, busy}, 32'h0);
`endif

    access(1'b1, 4'hF, 10'h010, 32'hDEAD_BEEF, 32'h0, "wr_beef");
    access(1'b0, 4'hF, 10'h010, 32'h0, 32'hDEAD_BEEF, "rd_beef");

    access(1'b1, 4'hF, 10'h020, 32'h1122_3344, 32'h0, "wr_full");
    access(1'b1, 4'b0101, 10'h020, 32'hAABB_CCDD, 32'h0, "wr_lanes");
    access(1'b0, 4'hF, 10'h020, 32'h0, 32'h11BB_33DD, "rd_lanes");

    access(1'b1, 4'h0, 10'h010, 32'hFFFF_FFFF, 32'h0, "wr_nosel");
    access(1'b0, 4'hF, 10'h010, 32'h0, 32'hDEAD_BEEF, "rd_nosel");

    for (int i = 0; i < 4; i++) begin
      access(1'b1, 4'hF, 10'(10'h040 + 4 * i), 32'hC0DE_0000 | i, 32'h0, "wr_b2b");
    end
    // Four back-to-back reads with stb held high throughout.
    @(negedge clk);
    cyc = 1'b1; stb = 1'b1; we = 1'b0; sel = 4'hF; adr = 10'h040;
    k = 0; pat = 8'h00;
    for (int i = 0; i < 8; i++) begin
      #1;
      pat = {pat[6:0], ack};
      check("b2b_en_in_ack", {31'h0, ack & ram_en}, 32'h0);
      if (ack) begin
        check("b2b_dat", dat_o, 32'hC0DE_0000 | k);
        k++;
        adr = 10'(10'h040 + 4 * k);
      end
      @(negedge clk);
    end
    cyc = 1'b0; stb = 1'b0; adr = '0;
    check("b2b_pattern", {24'h0, pat}, 32'h0000_0055);

    // Reset asserted during the ack cycle of a read.
    access(1'b1, 4'hF, 10'h080, 32'h1234_5678, 32'h0, "wr_pre_rst");
    @(negedge clk);
    cyc = 1'b1; stb = 1'b1; we = 1'b0; sel = 4'hF; adr = 10'h080;
    @(posedge clk); #1;
    check("mid_ack", {31'h0, ack}, 32'h1);
    check("mid_dat", dat_o, 32'h1234_5678);
    #1 rst = 1'b1;
    #1;
    check("mid_rst_ack", {31'h0, ack}, 32'h0);
    check("mid_rst_dat", dat_o, 32'h0);
    check("mid_rst_en", {31'h0, ram_en}, 32'h0);
    @(negedge clk);
    cyc = 1'b0; stb = 1'b0; adr = '0;
    @(negedge clk);
    rst = 1'b0;
    @(posedge clk); #1;
    wait_ready();
`ifdef DFFRAM_WB_ZEROIZE_EN
    access(1'b0, 4'hF, 10'h080, 32'h0, 32'h0, "rd_post_rst");
`else
    access(1'b0, 4'hF, 10'h080, 32'h0, 32'h1234_5678, "rd_post_rst");
`endif
    access(1'b1, 4'hF, 10'h0FC, 32'hCAFE_F00D, 32'h0, "wr_post_rst");
    access(1'b0, 4'hF, 10'h0FC, 32'h0, 32'hCAFE_F00D, "rd_post_rst2");

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/dffram_wb_port.md
# dffram_wb_port

Single-port Wishbone-classic responder that acts as the initiator on a DFFRAM macro port (CLK/EN0/WE0[3:0]/A0/Di0/Do0). It turns bus cycles into single-cycle RAM strobes, captures read data, and returns a registered acknowledge. It sits between the SoC bus fabric and one DFFRAM instance (256x32 by default). It optionally zero-fills the whole array after reset.

## Interface
- AW, 8, RAM word-address width; depth is 2^AW words of 32 bits.
- CLK  in  1  system clock; shared with the RAM's CLK.
- RST  in  1  asynchronous, active-high reset.
- wb_cyc_i  in  1  bus cycle valid.
- wb_stb_i  in  1  strobe.
- wb_we_i  in  1  1 = write, 0 = read.
- wb_sel_i  in  4  byte-lane select; bit n selects bits 8n+7:8n.
- wb_adr_i  in  AW+2  byte address; bits 1:0 are ignored.
- wb_dat_i  in  32  write data.
- wb_dat_o  out  32  read data; valid only while wb_ack_o=1 on a read.
- wb_ack_o  out  1  one-cycle acknowledge.
- busy_o  out  1  zero-fill in progress; bus requests are stalled.
- ram_en  out  1  drives the RAM's EN0.
- ram_we  out  4  drives the RAM's WE0.
- ram_a  out  AW  drives the RAM's A0.
- ram_di  out  32  drives the RAM's Di0.
- ram_do  in  32  from the RAM's Do0.

## Operation
- RAM contract:
  - On a CLK rising edge with ram_en=1, every byte lane whose ram_we bit is set is written from ram_di.
  - ram_do presents the word at ram_a after that edge and holds until the next enabled edge.
- States: INIT, ZERO, IDLE, ACK. The ZERO state exists only with the macro defined.
- INIT is the reset state. It moves to ZERO (macro defined) or IDLE (macro undefined) on the first edge after RST deasserts.
- IDLE, when wb_cyc_i & wb_stb_i:
  - Combinationally drive ram_en=1, ram_a=wb_adr_i[AW+1:2], ram_di=wb_dat_i.
  - Drive ram_we = wb_we_i ? wb_sel_i : 4'h0.
  - Move to ACK at the next edge.
- ACK:
  - wb_ack_o=1 and ram_en=0.
  - On a read, wb_dat_o=ram_do.
  - Always return to IDLE at the next edge; a back-to-back request is accepted there.
- A write with wb_sel_i=0 still strobes the RAM (no lanes written) and is still acknowledged.
- Whenever the RAM port is not being strobed: ram_en=0, ram_we=0, ram_a=0, ram_di=0.
- wb_dat_o is 0 whenever wb_ack_o=0 and during write acks.
- If wb_cyc_i drops while in ACK, the ack still pulses for that cycle and the write has already committed. The master ignores the ack.

## Timing
- Reset values, held while RST=1 (INIT state):
  - wb_ack_o=0, wb_dat_o=0.
  - ram_en=0, ram_we=0, ram_a=0, ram_di=0.
  - busy_o=1 with the macro defined, 0 without it.
- Latency: request in cycle N produces wb_ack_o in cycle N+1. Each access occupies 2 cycles, so peak throughput is one access per 2 cycles.
- wb_ack_o is registered and never high for two consecutive cycles.
- Read data is taken combinationally from ram_do during the ACK cycle; there is no extra pipeline register.
- RST asserted mid-access:
  - Outputs go to their reset values immediately.
  - An in-flight write may or may not have committed.
  - No ack is issued for that access.

## Configuration
- Macro DFFRAM_WB_ZEROIZE_EN.
- Defined:
  - INIT moves to ZERO.
  - ZERO runs an AW-bit counter from 0 to 2^AW-1, one word per cycle, with ram_en=1, ram_we=4'hF, ram_a=counter, ram_di=0.
  - After the last word, the next state is IDLE and busy_o falls. The fill takes exactly 2^AW cycles after INIT.
  - Bus requests during INIT/ZERO get no ack and are serviced once IDLE is reached.
  - RST during ZERO restarts the fill from word 0.
- Undefined: the counter and ZERO state are absent, busy_o is tied 0, and RAM contents after reset are undefined.

## Test plan
- Write then read:
  - Write 0xDEADBEEF to byte address 0x010 with sel=4'hF.
  - Read address 0x010.
  - Required: each ack arrives one cycle after stb, ram_a=0x04, read returns 0xDEADBEEF.
- Byte lanes:
  - Write 0x11223344 with sel=4'hF, then write 0xAABBCCDD to the same word with sel=4'b0101.
  - Required: read returns 0x11BB33DD.
- Back-to-back:
  - Hold stb high for 4 reads at consecutive words.
  - Required: ack pattern 0101_0101, each data word matches its address, ram_en is never high in an ack cycle.
- Zeroize (macro defined, AW=8):
  - Release reset.
  - Required: busy_o stays high for exactly 257 cycles after release (INIT + 256).
  - Required: a read of 0x3FC issued during the fill acks only after busy_o falls and returns 0x00000000.
- Reset mid-access:
  - Assert RST in the ACK cycle of a read.
  - Required: wb_ack_o and wb_dat_o drop to 0 asynchronously, and the next request after release is acked normally.
